uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver: the downstream counterpart of the UART transmitter. Samples the RX line, recovers 8N1-style frames (1 start bit, DATA_WIDTH data bits LSB first, ≥1 stop bit), and presents each received word with a one-cycle valid strobe. Sits between the board RX pin and the consumer logic (loopback checker, FIFO, display).

## Interface
- CLK_FREQ, 50000000: system clock frequency, Hz
- BAUDRATE, 9600: line bit rate; BIT_TICKS = CLK_FREQ / BAUDRATE (integer division), HALF_TICKS = BIT_TICKS / 2
- DATA_WIDTH, 8: data bits per frame, 1..15

- clk  input  1  system clock, all logic on posedge
- reset  input  1  asynchronous, active-high; clears all state immediately
- line  input  1  RX line, asynchronous to clk, idles high
- data  output  DATA_WIDTH  last correctly framed word; reset 0; changes only together with valid
- valid  output  1  one-cycle pulse, data updated this cycle; reset 0
- frame_error  output  1  one-cycle pulse, stop bit sampled low; reset 0
- busy  output  1  high whenever not IDLE; reset 0

## Operation
- line passes a 2-flop synchronizer (flops reset to 1) → line_s; one more register holds line_d (reset 1) for edge detect.
- Bit counter cnt: width clog2(BIT_TICKS), cleared to 0 on every state entry, increments every cycle in non-IDLE states. Bit index idx: 0..DATA_WIDTH-1. Shift register sh: DATA_WIDTH bits.
- IDLE: on line_d==1 && line_s==0 (falling edge) → START. A line held low (break) never re-triggers until it returns high.
- START: when cnt==HALF_TICKS-1, sample line_s: 0 → DATA (idx=0); 1 → IDLE (glitch rejected, no pulse).
- DATA: when cnt==BIT_TICKS-1, sample line_s into sh at position idx (LSB first); idx==DATA_WIDTH-1 → STOP, else idx+1, cnt cleared.
- STOP: when cnt==BIT_TICKS-1, sample line_s: 1 → data<=sh, valid=1; 0 → frame_error=1, data unchanged. Either way → IDLE same edge.
- Return to IDLE happens mid-stop-bit; a start bit immediately following one stop bit is caught.
- valid and frame_error never high together; never high for two consecutive cycles.
- reset asserted anywhere: state IDLE, counters, sh, outputs to reset values immediately; a partial frame is discarded; the next full frame after reset release is received normally.

## Timing
- Sampling points: start bit at HALF_TICKS, each data bit and stop bit at exactly BIT_TICKS intervals thereafter (mid-bit).
- Latency: line pin fall at cycle 0 → valid/frame_error high at cycle 3 + HALF_TICKS + (DATA_WIDTH+1)·BIT_TICKS - 1 (2 sync + 1 edge register + counting), exactly, for line changes aligned to clk.
- busy rises the cycle after the edge is detected, falls in the same cycle valid/frame_error pulses.
- Tolerates transmitter baud mismatch up to ±4% for DATA_WIDTH=8.
- No backpressure: consumer must capture data on valid; data holds until the next valid.

## Structure
- Shared header uart_defs.vh: state encoding (IDLE, START, DATA, STOP, 2 bits) and the BIT_TICKS/HALF_TICKS derivation, also usable by uart_tx.
- One sub-module: sync_2ff (2-flop synchronizer, parameterised reset value, async active-high reset), reused for any other asynchronous input.
- Counter and FSM stay inline; clock_div is not reused (no half-period phase, no async reset).

## Test plan
Bench parameters CLK_FREQ=1600, BAUDRATE=100 → BIT_TICKS=16, HALF_TICKS=8, DATA_WIDTH=8.
- Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) → valid high exactly one cycle at cycle 3+8+144-1=154 after start edge, data=0xA5, frame_error never high.
- Frames 0x00 then 0xFF back-to-back with one stop bit → two valid pulses 160 cycles apart, data 0x00 then 0xFF.
- Low glitch of 4 cycles on idle line → busy pulses then drops at start sample, no valid/frame_error, next frame 0x3C received correctly.
- Frame 0x3C with stop bit driven 0, prior data 0xA5 → frame_error one cycle, valid 0, data stays 0xA5; line held low afterwards produces no further start until it goes high.
- reset asserted mid-DATA of frame 0x55 → busy/valid/frame_error/data 0 immediately, no pulse for the aborted frame; following frame 0x81 → data=0x81.
- Loopback uart_tx → uart_rx, 256 words 0x00..0xFF at default-ratio params → every word received in order, zero frame_error.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// the baud-timing derivations (also usable by a matching transmitter).
package uart_rx_pkg;

  // Receiver FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Clock cycles per bit period (integer division, truncates).
  function automatic int bit_ticks(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Cycles from start-bit edge to the middle of the start bit.
  function automatic int half_ticks(input int clk_freq, input int baud);
    return bit_ticks(clk_freq, baud) / 2;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous input. Reset value is a
// parameter so idle-high lines (UART RX) come out of reset inactive.
module sync_2ff #(
  parameter int   WIDTH   = 1,
  parameter logic RST_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Next-state: shift the input one stage per clock.
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
  end

  // Synchronizer stages; both come out of reset at RST_VAL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= {WIDTH{RST_VAL}};
      sync_q <= {WIDTH{RST_VAL}};
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DATA_WIDTH data bits LSB first, >=1 stop bit.
// The line is synchronized, a falling edge on an idle line starts a frame,
// and every bit is sampled mid-bit by a cycle counter. Each frame ends with
// a one-cycle valid (good stop bit) or frame_error (stop bit low) pulse.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int BIT_TICKS  = bit_ticks(CLK_FREQ, BAUDRATE);
  localparam int HALF_TICKS = half_ticks(CLK_FREQ, BAUDRATE);
  localparam int CNT_W      = cnt_width(BIT_TICKS);
  localparam int IDX_W      = cnt_width(DATA_WIDTH);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  logic line_s;
  logic line_d_q, line_d_d;
  logic fall;

  uart_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic [DATA_WIDTH-1:0] sh_q,    sh_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q,  ferr_d;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (line),
    .dout  (line_s)
  );

  // Start condition is a high-to-low transition; a held-low line never
  // re-triggers because line_d stays low until the line returns high.
  assign fall = line_d_q & ~line_s;

  // Next-state and output logic for the receive FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    line_d_d = line_s;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      // Re-check the line at mid start bit so short glitches are dropped.
      ST_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!line_s) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      // One sample per bit period, written LSB first.
      ST_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BIT_LAST) begin
          cnt_d       = '0;
          sh_d[idx_q] = line_s;
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      // Mid stop bit: publish or flag, then go idle straight away so a
      // start bit right after a single stop bit is still seen.
      ST_STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (line_s) begin
            data_d  = sh_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset drops any partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_q     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      line_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      line_d_q <= line_d_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: table of frames, hand-written
// corner cases (glitch, frame error with held-low line, reset mid-frame),
// and a randomized serializer stream checked against an event model.
module tb_uart_rx;

  localparam int CLK_FREQ = 1600;
  localparam int BAUDRATE = 100;
  localparam int DW       = 8;
  localparam int BIT      = CLK_FREQ / BAUDRATE;
  localparam int HALF     = BIT / 2;
  localparam int LAT      = 3 + HALF + (DW + 1) * BIT - 1;
  localparam int LOG_N    = 131072;

  logic          clk = 1'b0;
  logic          reset;
  logic          line;
  logic [DW-1:0] data;
  logic          valid;
  logic          frame_error;
  logic          busy;

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUDRATE   (BAUDRATE),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .line        (line),
    .data        (data),
    .valid       (valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic          v;
    logic          fe;
    logic [DW-1:0] d;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  bit  busy_log [LOG_N];
  logic [DW-1:0] prev_data = '0;

  // Record every pulse or data change, plus busy per cycle.
  always @(negedge clk) begin
    if (cyc < LOG_N) busy_log[cyc] <= busy;
    if (reset) begin
      prev_data <= data;
    end else begin
      if (valid || frame_error || data !== prev_data)
        obs_q.push_back('{cyc, valid, frame_error, data});
      prev_data <= data;
    end
  end

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    line = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stopv, output int c);
    c = cyc;
    drive(1'b0, BIT);
    for (int i = 0; i < DW; i++) drive(d[i], BIT);
    drive(stopv, BIT);
  endtask

  // Line first sampled one edge after c; pulse LAT cycles after that.
  task automatic model_expect(input int c, input logic [DW-1:0] d, input logic stopv);
    exp_q.push_back('{c + 1 + LAT, stopv, !stopv, stopv ? d : last_data});
    if (stopv) last_data = d;
  endtask

  task automatic check_events(input string tag);
    ev_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s missing: got no pulse, want cyc=%0d v=%0b fe=%0b d=%0h",
                 tag, e.cyc, e.v, e.fe, e.d);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc != e.cyc || o.v !== e.v || o.fe !== e.fe || o.d !== e.d) begin
          errors++;
          $display("FAIL %s event: got cyc=%0d v=%0b fe=%0b d=%0h, want cyc=%0d v=%0b fe=%0b d=%0h",
                   tag, o.cyc, o.v, o.fe, o.d, e.cyc, e.v, e.fe, e.d);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL %s extra: got %0d unexpected events (first cyc=%0d v=%0b fe=%0b d=%0h), want 0",
               tag, obs_q.size(), obs_q[0].cyc, obs_q[0].v, obs_q[0].fe, obs_q[0].d);
      obs_q.delete();
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          stopv;
    int            gap;
    logic          ev;
    logic          ef;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int c, c2, gap;
    logic [DW-1:0] w;
    logic stopv, any_busy;

    tbl[0] = '{8'h00, 1'b1, 0,  1'b1, 1'b0, 8'h00};
    tbl[1] = '{8'hFF, 1'b1, 20, 1'b1, 1'b0, 8'hFF};
    tbl[2] = '{8'hC3, 1'b1, 5,  1'b1, 1'b0, 8'hC3};
    tbl[3] = '{8'h3C, 1'b0, 8,  1'b0, 1'b1, 8'hC3};
    tbl[4] = '{8'h7E, 1'b1, 3,  1'b1, 1'b0, 8'h7E};
    tbl[5] = '{8'h01, 1'b1, 0,  1'b1, 1'b0, 8'h01};
    tbl[6] = '{8'h80, 1'b1, 12, 1'b1, 1'b0, 8'h80};

    line  = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", 32'(data), 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_ferr", 32'(frame_error), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    drive(1'b1, 20);

    // Single frame, exact latency and busy window.
    send_frame(8'hA5, 1'b1, c);
    model_expect(c, 8'hA5, 1'b1);
    drive(1'b1, 2 * BIT);
    check_events("a5");
    chk("a5_busy_pre", 32'(busy_log[c + 2]), 32'h0);
    chk("a5_busy_rise", 32'(busy_log[c + 3]), 32'h1);
    chk("a5_busy_last", 32'(busy_log[c + LAT]), 32'h1);
    chk("a5_busy_fall", 32'(busy_log[c + 1 + LAT]), 32'h0);

    // Table: back-to-back frames, a frame error, varied gaps.
    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].d, tbl[i].stopv, c);
      exp_q.push_back('{c + 1 + LAT, tbl[i].ev, tbl[i].ef, tbl[i].ed});
      drive(1'b1, tbl[i].gap);
    end
    last_data = 8'h80;
    drive(1'b1, 2 * BIT);
    check_events("table");

    // Short low glitch on an idle line is rejected at the start sample.
    c = cyc;
    drive(1'b0, 4);
    drive(1'b1, 3 * BIT);
    chk("glitch_busy_pre", 32'(busy_log[c + 2]), 32'h0);
    chk("glitch_busy_rise", 32'(busy_log[c + 3]), 32'h1);
    chk("glitch_busy_hold", 32'(busy_log[c + 10]), 32'h1);
    chk("glitch_busy_drop", 32'(busy_log[c + 11]), 32'h0);
    check_events("glitch");
    send_frame(8'h3C, 1'b1, c);
    model_expect(c, 8'h3C, 1'b1);
    drive(1'b1, 2 * BIT);
    check_events("after_glitch");

    // Frame error with prior data A5, then the line is held low.
    send_frame(8'hA5, 1'b1, c);
    model_expect(c, 8'hA5, 1'b1);
    drive(1'b1, BIT);
    send_frame(8'h3C, 1'b0, c2);
    model_expect(c2, 8'h3C, 1'b0);
    drive(1'b0, 4 * BIT);
    any_busy = 1'b0;
    for (int k = c2 + 1 + LAT; k < c2 + 10 * BIT + 4 * BIT; k++) any_busy |= busy_log[k];
    chk("break_no_restart", 32'(any_busy), 32'h0);
    chk("ferr_data_hold", 32'(data), 32'hA5);
    drive(1'b1, 2 * BIT);
    check_events("ferr");

    // Reset in the middle of the data bits of 0x55.
    w = 8'h55;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(w[i], BIT);
    drive(w[4], 8);
    chk("pre_reset_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_ferr", 32'(frame_error), 32'h0);
    chk("rst_data", 32'(data), 32'h0);
    line = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    last_data = '0;
    drive(1'b1, 2 * BIT);
    check_events("reset_abort");
    send_frame(8'h81, 1'b1, c);
    model_expect(c, 8'h81, 1'b1);
    drive(1'b1, 2 * BIT);
    check_events("after_reset");
    chk("after_reset_data", 32'(data), 32'h81);

    // Serialized stream of all byte values in order, random idle gaps.
    for (int v = 0; v < 256; v++) begin
      send_frame(8'(v), 1'b1, c);
      model_expect(c, 8'(v), 1'b1);
      drive(1'b1, $urandom_range(0, 20));
    end
    drive(1'b1, 2 * BIT);
    check_events("loopback");

    // Random words with occasional bad stop bits.
    for (int n = 0; n < 48; n++) begin
      w     = 8'($urandom);
      stopv = ($urandom_range(0, 5) != 0);
      send_frame(w, stopv, c);
      model_expect(c, w, stopv);
      gap = stopv ? $urandom_range(0, 20) : $urandom_range(3, 20);
      drive(1'b1, gap);
    end
    drive(1'b1, 2 * BIT);
    check_events("random");
    chk("final_data", 32'(data), 32'(last_data));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
